// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: watches the single-cycle CPU (pc, instruction, $v0) and
// raises a registered halt on exit syscall, self-loop or timeout.
// Optional trace output: define RUN_MONITOR_TRACE_EN.
module cpu_run_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned STALL_LIMIT    = 4,
  parameter int unsigned CW             = 32,
  parameter int unsigned HIST_AW        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        pc,
  input  logic [31:0]        instruction,
  input  logic [31:0]        v0,
  output logic               running,
  output logic               halted,
  output logic               halt_pulse,
  output logic [1:0]         halt_cause,
  output logic [31:0]        halt_pc,
  output logic [CW-1:0]      cycle_count,
  input  logic [HIST_AW-1:0] hist_sel,
  output logic [31:0]        hist_pc
);

  localparam int unsigned DEPTH = 2 ** HIST_AW;
  localparam int unsigned SW    = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_SYSCALL = 2'b01;
  localparam logic [1:0] CAUSE_LOOP    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         prev_pc_q;
  logic [SW-1:0]       stall_q;
  logic                first_q;
  logic [HIST_AW-1:0]  wptr_q;
  logic [31:0]         hist_q [DEPTH];

  logic                sample_c;
  logic                halt_det_c;
  logic [1:0]          cause_c;
  logic                syscall_c;
  logic                repeat_c;
  logic                loop_c;
  logic                tmo_c;
  logic [HIST_AW-1:0]  hist_idx_c;

  // Halt term decode on the current CPU sample
  always_comb begin
    syscall_c = (instruction == 32'h0000_000C) && (v0 == 32'd10);
    repeat_c  = !first_q && (pc == prev_pc_q);
    loop_c    = repeat_c && ((32'(stall_q) + 32'd1) >= STALL_LIMIT);
    tmo_c     = (cycle_count == CW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state logic; start always restarts and beats a same-cycle halt
  always_comb begin
    state_d    = state_q;
    sample_c   = 1'b0;
    halt_det_c = 1'b0;
    cause_c    = CAUSE_NONE;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          sample_c = 1'b1;
          if (syscall_c) begin
            halt_det_c = 1'b1;
            cause_c    = CAUSE_SYSCALL;
          end else if (loop_c) begin
            halt_det_c = 1'b1;
            cause_c    = CAUSE_LOOP;
          end else if (tmo_c) begin
            halt_det_c = 1'b1;
            cause_c    = CAUSE_TIMEOUT;
          end
          if (halt_det_c) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Counters, history, halt capture and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      running     <= 1'b0;
      halted      <= 1'b0;
      halt_pulse  <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      halt_pc     <= '0;
      cycle_count <= '0;
      prev_pc_q   <= '0;
      stall_q     <= '0;
      first_q     <= 1'b0;
      wptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      running    <= (state_d == S_RUN);
      halted     <= (state_d == S_HALTED);
      halt_pulse <= 1'b0;
      if (start) begin
        cycle_count <= '0;
        stall_q     <= '0;
        first_q     <= 1'b1;
        wptr_q      <= '0;
        halt_cause  <= CAUSE_NONE;
        halt_pc     <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      end else if (sample_c) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CW'(1);
        hist_q[wptr_q] <= pc;
        wptr_q         <= wptr_q + HIST_AW'(1);
        prev_pc_q      <= pc;
        first_q        <= 1'b0;
        if (repeat_c) begin
          if (stall_q != '1) stall_q <= stall_q + SW'(1);
        end else begin
          stall_q <= '0;
        end
        if (halt_det_c) begin
          halt_pulse <= 1'b1;
          halt_cause <= cause_c;
          halt_pc    <= pc;
        end
      end
    end
  end

  // History read: index 0 is the most recently written entry
  always_comb begin
    hist_idx_c = wptr_q - HIST_AW'(1) - hist_sel;
    hist_pc    = hist_q[hist_idx_c];
  end

`ifdef RUN_MONITOR_TRACE_EN
  // Simulation trace of every sampled cycle and of the halt event
  always @(posedge clk) begin
    if (!reset && sample_c) begin
      $display("%4t | %h | %h", $time, pc, instruction);
      if (halt_det_c)
        $display("HALT cause=%0d pc=%h cycles=%0d", cause_c, pc,
                 (cycle_count == '1) ? cycle_count : cycle_count + CW'(1));
    end
  end
`else
  // Trace disabled: no simulation text
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: vector table plus timeout/history sequence.
module tb_cpu_run_monitor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] v0;
  logic        running;
  logic        halted;
  logic        halt_pulse;
  logic [1:0]  halt_cause;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;
  logic [1:0]  hist_sel;
  logic [31:0] hist_pc;

  int n_checks;
  int n_fail;

  cpu_run_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .v0          (v0),
    .running     (running),
    .halted      (halted),
    .halt_pulse  (halt_pulse),
    .halt_cause  (halt_cause),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count),
    .hist_sel    (hist_sel),
    .hist_pc     (hist_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] v0;
    logic        e_run;
    logic        e_hlt;
    logic        e_pls;
    logic [1:0]  e_cause;
    logic [31:0] e_hpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [31:0] p,
                       input logic [31:0] i, input logic [31:0] v);
    @(negedge clk);
    reset       = r;
    start       = s;
    pc          = p;
    instruction = i;
    v0          = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " running"},     32'(running),     32'(e.e_run));
    chk({tag, " halted"},      32'(halted),      32'(e.e_hlt));
    chk({tag, " halt_pulse"},  32'(halt_pulse),  32'(e.e_pls));
    chk({tag, " halt_cause"},  32'(halt_cause),  32'(e.e_cause));
    chk({tag, " halt_pc"},     halt_pc,          e.e_hpc);
    chk({tag, " cycle_count"}, cycle_count,      e.e_cnt);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; pc = '0; instruction = '0; v0 = '0; hist_sel = '0;

    //          rst  st   pc      ins     v0   run hlt pls cause hpc    cnt
    // reset, idle, start
    tbl.push_back('{1'b1,1'b0,32'h0,  32'h0, 32'd0, 0,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b1,1'b0,32'h0,  32'h0, 32'd0, 0,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h0,  32'h0, 32'd0, 0,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b1,32'h0,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd0});
    // exit syscall at pc=8
    tbl.push_back('{1'b0,1'b0,32'h0,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd1});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd2});
    tbl.push_back('{1'b0,1'b0,32'h8,  32'hC, 32'd10,0,1,1,2'd1,32'h8, 32'd3});
    tbl.push_back('{1'b0,1'b0,32'h100,32'hC, 32'd10,0,1,0,2'd1,32'h8, 32'd3});
    // self-loop on pc=4; print syscall (v0=4) is not an exit
    tbl.push_back('{1'b0,1'b1,32'h0,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h0,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd1});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd2});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'hC, 32'd4, 1,0,0,2'd0,32'h0, 32'd3});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd4});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd5});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 0,1,1,2'd2,32'h4, 32'd6});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 0,1,0,2'd2,32'h4, 32'd6});
    // first RUN cycle equal to old prev_pc is not a repeat; syscall beats loop
    tbl.push_back('{1'b0,1'b1,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd1});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd2});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd3});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd4});
    tbl.push_back('{1'b0,1'b0,32'h4,  32'hC, 32'd10,0,1,1,2'd1,32'h4, 32'd5});
    // restart from HALTED, start beats halt, reset mid-RUN
    tbl.push_back('{1'b0,1'b1,32'h50, 32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h40, 32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd1});
    tbl.push_back('{1'b0,1'b0,32'h44, 32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd2});
    tbl.push_back('{1'b0,1'b1,32'h48, 32'hC, 32'd10,1,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h48, 32'h0, 32'd0, 1,0,0,2'd0,32'h0, 32'd1});
    tbl.push_back('{1'b1,1'b0,32'h4C, 32'hC, 32'd10,0,0,0,2'd0,32'h0, 32'd0});
    tbl.push_back('{1'b0,1'b0,32'h4C, 32'hC, 32'd10,0,0,0,2'd0,32'h0, 32'd0});

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].st, tbl[k].pc, tbl[k].ins, tbl[k].v0);
      chk_all($sformatf("vec%0d", k), tbl[k]);
    end

    // History is cleared after reset
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      chk($sformatf("hist_reset sel%0d", s), hist_pc, 32'h0);
    end
    hist_sel = '0;

    // Timeout: 100 sampled cycles with incrementing pc and no exit
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'd0);
    chk("tmo start running", 32'(running), 32'd1);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 32'd0);
      if (i == 98) begin
        chk("tmo pre halted",  32'(halted), 32'd0);
        chk("tmo pre count",   cycle_count, 32'd99);
      end
    end
    chk_all("tmo", '{1'b0,1'b0,32'h0,32'h0,32'd0, 0,1,1,2'd3, 32'h1000 + 32'd396, 32'd100});
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      chk($sformatf("hist sel%0d", s), hist_pc, 32'h1000 + 32'(4 * (99 - s)));
    end
    hist_sel = '0;
    drive(1'b0, 1'b0, 32'h2000, 32'hC, 32'd10);
    chk_all("tmo hold", '{1'b0,1'b0,32'h0,32'h0,32'd0, 0,1,0,2'd3, 32'h1000 + 32'd396, 32'd100});
    hist_sel = 2'd0;
    #1;
    chk("hist frozen", hist_pc, 32'h1000 + 32'd396);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
